// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// op encodings and FSM state type.
package mdu_pkg;

    localparam logic [2:0] MDU_OP_MULT  = 3'b000;
    localparam logic [2:0] MDU_OP_MULTU = 3'b001;
    localparam logic [2:0] MDU_OP_DIV   = 3'b010;
    localparam logic [2:0] MDU_OP_DIVU  = 3'b011;
    localparam logic [2:0] MDU_OP_MTHI  = 3'b100;
    localparam logic [2:0] MDU_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        MDU_IDLE  = 2'd0,
        MDU_CALC  = 2'd1,
        MDU_FIXUP = 2'd2
    } mdu_state_e;

    function automatic logic mdu_op_signed(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: shift in a dividend bit, trial
// subtract the divisor, keep the difference if it did not underflow.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_sh;
    logic [WIDTH:0] w_diff;

    assign w_sh   = {i_rem, i_bit};
    assign w_diff = w_sh - {1'b0, i_div};
    // Partial remainder stays below the divisor, so bit WIDTH is a borrow flag.
    assign o_q    = ~w_diff[WIDTH];
    assign o_rem  = o_q ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];

endmodule

// File: rtl/mdu_seq.sv
// Sequential MULT/DIV unit with HI/LO registers and ready/done handshake.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg_res;
    logic [WIDTH-1:0]   w_drem;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_signed  = mdu_op_signed(op);
    assign w_mag_a   = (w_signed && a[WIDTH-1]) ? ('0 - a) : a;
    assign w_mag_b   = (w_signed && b[WIDTH-1]) ? ('0 - b) : b;
    assign w_neg_res = w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem (r_acc_hi),
        .i_bit (r_acc_lo[WIDTH-1]),
        .i_div (r_opb),
        .o_rem (w_drem),
        .o_q   (w_qbit)
    );

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fprod;
    assign w_fprod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`else
    logic [WIDTH:0] w_msum;
    // Multiplier sits in acc_lo and shifts out LSB-first as the product fills in.
    assign w_msum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
`endif

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_lo ? ('0 - w_prod) : w_prod;
    assign w_q_fix    = r_neg_lo ? ('0 - r_acc_lo) : r_acc_lo;
    assign w_r_fix    = r_neg_hi ? ('0 - r_acc_hi) : r_acc_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= MDU_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MDU_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            MDU_OP_MTHI: r_hi <= a;
                            MDU_OP_MTLO: r_lo <= a;
                            MDU_OP_MULT, MDU_OP_MULTU: begin
                                r_is_div <= 1'b0;
                                r_neg_lo <= w_neg_res;
                                r_neg_hi <= 1'b0;
                                r_cnt    <= '0;
`ifdef MDU_FAST_MUL_EN
                                r_acc_hi <= w_fprod[2*WIDTH-1:WIDTH];
                                r_acc_lo <= w_fprod[WIDTH-1:0];
                                r_state  <= MDU_FIXUP;
`else
                                r_acc_hi <= '0;
                                r_acc_lo <= w_mag_b;
                                r_opb    <= w_mag_a;
                                r_state  <= MDU_CALC;
`endif
                            end
                            MDU_OP_DIV, MDU_OP_DIVU: begin
                                r_is_div <= 1'b1;
                                r_cnt    <= '0;
                                r_acc_hi <= '0;
                                if (b == '0) begin
                                    r_acc_lo <= '0;
                                    r_neg_lo <= 1'b0;
                                    r_neg_hi <= 1'b0;
                                    r_state  <= MDU_FIXUP;
                                end else begin
                                    r_acc_lo <= w_mag_a;
                                    r_opb    <= w_mag_b;
                                    r_neg_lo <= w_neg_res;
                                    r_neg_hi <= w_signed && a[WIDTH-1];
                                    r_state  <= MDU_CALC;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MDU_CALC: begin
                    if (flush) begin
                        r_state <= MDU_IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_acc_hi <= w_drem;
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_qbit};
                        end else begin
`ifndef MDU_FAST_MUL_EN
                            r_acc_hi <= w_msum[WIDTH:1];
                            r_acc_lo <= {w_msum[0], r_acc_lo[WIDTH-1:1]};
`endif
                        end
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(WIDTH - 1))
                            r_state <= MDU_FIXUP;
                    end
                end
                MDU_FIXUP: begin
                    r_state <= MDU_IDLE;
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_r_fix;
                            r_lo <= w_q_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= MDU_IDLE;
            endcase
        end
    end

    assign ready = (r_state == MDU_IDLE);
    assign busy  = ~ready;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized self-checking bench for mdu_seq against an arithmetic
// reference model of HI/LO and latency.
module tb_mdu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mdu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, output int lat);
        logic signed [63:0] sx, sy, sp, sq, sr;
        logic [63:0] up;
        sx = {{32{x[W-1]}}, x};
        sy = {{32{y[W-1]}}, y};
        lat = 0;
        case (o)
            3'd0: begin
                sp = sx * sy;
                {m_hi, m_lo} = sp;
`ifdef MDU_FAST_MUL_EN
                lat = 1;
`else
                lat = W + 1;
`endif
            end
            3'd1: begin
                up = {32'd0, x} * {32'd0, y};
                {m_hi, m_lo} = up;
`ifdef MDU_FAST_MUL_EN
                lat = 1;
`else
                lat = W + 1;
`endif
            end
            3'd2, 3'd3: begin
                if (y == '0) begin
                    m_hi = '0;
                    m_lo = '0;
                    lat = 1;
                end else begin
                    if (o == 3'd2) begin
                        sq = sx / sy;
                        sr = sx % sy;
                        m_lo = sq[W-1:0];
                        m_hi = sr[W-1:0];
                    end else begin
                        m_lo = x / y;
                        m_hi = x % y;
                    end
                    lat = W + 1;
                end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input string tag);
        int n;
        int lat;
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        check({tag, "_rdy"}, 64'(ready), 64'(1));
        @(posedge clk);
        #1 start = 1'b0;
        if (o >= 3'd4) begin
            model(o, x, y, lat);
            check({tag, "_nodone"}, 64'(done), 64'(0));
            check({tag, "_idle"}, 64'(ready), 64'(1));
            check({tag, "_hi"}, 64'(hi), 64'(m_hi));
            check({tag, "_lo"}, 64'(lo), 64'(m_lo));
            return;
        end
        check({tag, "_busy"}, 64'(busy), 64'(1));
        check({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
        model(o, x, y, lat);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
        check({tag, "_rdy2"}, 64'(ready), 64'(1));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        int lat;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        rst_n = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_m3x7");
        check("mult_m3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'd3, 32'd100, 32'd7, "divu_100_7");
        check("divu_const", {hi, lo}, 64'h0000_0002_0000_000E);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        check("div_m7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        check("div_min_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(3'd2, 32'd5, 32'd0, "div_by0");
        run_op(3'd4, 32'h1234_5678, 32'd0, "mthi");
        run_op(3'd5, 32'h9ABC_DEF0, 32'd0, "mtlo");

        // flush mid-divide, with an ignored start during CALC
        @(negedge clk);
        op = 3'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        op = 3'd4; a = 32'hDEAD_BEEF; start = 1'b1;
        check("calc_notready", 64'(ready), 64'(0));
        @(posedge clk);
        #1 start = 1'b0;
        check("calc_start_ign", 64'(hi), 64'(m_hi));
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_ready", 64'(ready), 64'(1));
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        check("flush_nodone", 64'(seen), 64'(0));
        check("flush_hilo", {hi, lo}, {m_hi, m_lo});

        // async reset in the middle of a multiply
        @(negedge clk);
        op = 3'd1; a = 32'd5; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("arst_hi", 64'(hi), 64'(0));
        check("arst_lo", 64'(lo), 64'(0));
        check("arst_ready", 64'(ready), 64'(1));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] ro;
            ro = 3'($urandom_range(0, 7));
            run_op(ro, pick(), pick(), $sformatf("rnd%0d_op%0d", i, ro));
        end

        lat = 0;
        model(3'd6, '0, '0, lat);
        check("illegal_model_lat", 64'(lat), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
